// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, the 32-bit
// instruction field layout, opcode constants, the halt word and FSM states.
package ifetch_pkg;

    localparam int IFETCH_ADDR_W = 5;
    localparam int IFETCH_DATA_W = 32;

    // Field positions of the 32-bit instruction format
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 15;
    localparam int RS1_LSB    = 16;
    localparam int RS1_MSB    = 20;
    localparam int RS2_LSB    = 21;
    localparam int RS2_MSB    = 25;
    localparam int FUNCT7_LSB = 26;
    localparam int FUNCT7_MSB = 29;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_S = 7'b0100011;

    // An all-zero word stops the fetch stream
    localparam logic [IFETCH_DATA_W-1:0] HALT_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } ifetch_state_e;

    typedef struct packed {
        logic [3:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [3:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } inst_fields_t;

    // Split a raw word into its named fields (used by decode-side consumers)
    function automatic inst_fields_t split_fields(input logic [IFETCH_DATA_W-1:0] w);
        inst_fields_t f;
        f.opcode = w[OPCODE_MSB:OPCODE_LSB];
        f.rd     = w[RD_MSB:RD_LSB];
        f.funct3 = w[FUNCT3_MSB:FUNCT3_LSB];
        f.rs1    = w[RS1_MSB:RS1_LSB];
        f.rs2    = w[RS2_MSB:RS2_LSB];
        f.funct7 = w[FUNCT7_MSB:FUNCT7_LSB];
        return f;
    endfunction

    function automatic logic is_known_opcode(input logic [6:0] op);
        return (op == OPC_R) || (op == OPC_I) || (op == OPC_S);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch unit: instruction-memory read port and the
// valid/ready delivery channel towards decode.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    // Fetch unit side
    modport master (
        output imem_addr,
        input  imem_data,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc
    );

    // Memory/decode side
    modport slave (
        input  imem_addr,
        output imem_data,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc
    );
endinterface

// File: rtl/ifetch_skid_fifo.sv
// Small skid buffer holding {pc, data} entries between the memory response
// and decode. DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_skid_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] rd_view [DEPTH];

    // Pointer and occupancy bookkeeping; flush empties the buffer at once
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_q;
            // Each slot captures the pushed word when the write pointer selects it
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PTR_W'(gi))) entry_q <= push_data;
            end
            assign rd_view[gi] = entry_q;
        end
    endgenerate

    assign head_data = rd_view[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word addresses to a 1-cycle registered
// instruction memory, tags returned words with their PC and hands them to
// decode through a small skid buffer. Halts on an all-zero word or after
// LAST_ADDR. Optional performance counters under IFETCH_PERF_CNT_EN.
module instr_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int ADDR_W     = IFETCH_ADDR_W,
    parameter int DATA_W     = IFETCH_DATA_W,
    parameter int START_ADDR = 0,
    parameter int LAST_ADDR  = 31,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              busy,
    output logic              halted,
`ifdef IFETCH_PERF_CNT_EN
    output logic [15:0]       fetch_count,
    output logic [15:0]       stall_count,
`endif
    instr_fetch_unit_if.master bus
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    ifetch_state_e     state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              inflight_q;

    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_valid;
    logic               run;
    logic               pop;
    logic               push;
    logic               flush;
    logic               issue;
    logic               halt_now;
    logic               resp_zero;
    logic               resp_last;
    logic               has_room;
    logic [ADDR_W-1:0]  pc_inc;

    assign fifo_valid = (fifo_count != '0);
    assign run        = (state_q == ST_RUN);

    // Issue/response decisions; a redirect kills the arriving response and
    // a halting response suppresses any issue in the same cycle
    always_comb begin
        pop       = fifo_valid & bus.inst_ready;
        resp_zero = (bus.imem_data == DATA_W'(HALT_WORD));
        resp_last = (inflight_pc_q == ADDR_W'(LAST_ADDR));
        push      = run & inflight_q & ~redirect_valid & ~resp_zero;
        halt_now  = run & inflight_q & ~redirect_valid & (resp_zero | resp_last);
        has_room  = (int'(fifo_count) + int'(inflight_q) - int'(pop)) < FIFO_DEPTH;
        issue     = run & ~redirect_valid & ~halt_now & has_room;
        flush     = (run & redirect_valid) | (~run & start);
        // The PC parks on LAST_ADDR instead of wrapping to 0
        pc_inc    = (pc_q == ADDR_W'(LAST_ADDR)) ? pc_q : pc_q + ADDR_W'(1);
    end

    // Control FSM plus PC and in-flight tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= ADDR_W'(START_ADDR);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= issue;
            unique case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        pc_q    <= ADDR_W'(START_ADDR);
                    end
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_addr;
                    end else if (halt_now) begin
                        state_q <= ST_HALT;
                    end else if (issue) begin
                        inflight_pc_q <= pc_q;
                        pc_q          <= pc_inc;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ifetch_skid_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({inflight_pc_q, bus.imem_data}),
        .pop       (pop),
        .flush     (flush),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = fifo_valid;
    assign {bus.inst_pc, bus.inst_data} = fifo_valid ? fifo_head : '0;
    assign busy   = (state_q != ST_IDLE);
    assign halted = (state_q == ST_HALT) && !fifo_valid;

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetch_count_q;
    logic [15:0] stall_count_q;

    // Saturating counters of pushed words and back-pressured cycles
    always_ff @(posedge clk) begin
        if (rst || start) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (push && (fetch_count_q != 16'hFFFF))
                fetch_count_q <= fetch_count_q + 16'd1;
            if (fifo_valid && !bus.inst_ready && (stall_count_q != 16'hFFFF))
                stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected {pc,data}
// words into a queue, a negedge monitor pops and compares every accepted word.
module tb_instr_fetch_unit;
    import ifetch_pkg::*;

    typedef struct packed {
        logic [4:0]  pc;
        logic [31:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       redirect_valid;
    logic [4:0] redirect_addr;
    logic       busy;
    logic       halted;
`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    instr_fetch_unit_if #(.ADDR_W(5), .DATA_W(32)) bus_if ();

    instr_fetch_unit #(
        .ADDR_W(5), .DATA_W(32), .START_ADDR(0), .LAST_ADDR(31), .FIFO_DEPTH(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .busy           (busy),
        .halted         (halted),
`ifdef IFETCH_PERF_CNT_EN
        .fetch_count    (fetch_count),
        .stall_count    (stall_count),
`endif
        .bus            (bus_if)
    );

    always #5 clk = ~clk;

    // Registered-read instruction memory model
    logic [31:0] mem [32];
    always @(posedge clk) bus_if.imem_data <= mem[bus_if.imem_addr];

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    int   pops   = 0;
    int   max_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic [31:0] word_of(input int i);
        logic [31:0] w;
        w = 32'(OPC_I);
        w[11:7]  = 5'(i);
        w[20:16] = 5'(i);
        return w;
    endfunction

    task automatic load_prog(input int nonzero);
        for (int i = 0; i < 32; i++) mem[i] = (i < nonzero) ? word_of(i) : 32'h0;
    endtask

    task automatic push_range(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            e.pc = 5'(i);
            e.data = word_of(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        bus_if.inst_ready = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        pops = 0;
        max_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 64'(halted), 64'd1);
    endtask

    task automatic wait_pop_pc(input logic [4:0] target, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus_if.inst_valid && bus_if.inst_ready && bus_if.inst_pc == target) && n < budget);
        if (n >= budget) begin
            total++;
            $display("FAIL wait_pop_pc timeout actual=none required=pc %0d", target);
        end
    endtask

    // Monitor: compares every accepted word and checks hold-during-stall
    initial begin
        exp_t        e;
        logic        held = 1'b0;
        logic [4:0]  held_pc = '0;
        logic [31:0] held_data = '0;
        forever begin
            @(negedge clk);
            if (int'(dut.u_fifo.count_q) > max_cnt) max_cnt = int'(dut.u_fifo.count_q);
            if (bus_if.inst_valid) begin
                if (held) begin
                    chk("hold_pc", 64'(bus_if.inst_pc), 64'(held_pc));
                    chk("hold_data", 64'(bus_if.inst_data), 64'(held_data));
                end
                if (bus_if.inst_ready) begin
                    held = 1'b0;
                    pops++;
                    $display("pop pc=%0d data=%h", bus_if.inst_pc, bus_if.inst_data);
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_word actual=pc %0d data %h required=none",
                                 bus_if.inst_pc, bus_if.inst_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pc", 64'(bus_if.inst_pc), 64'(e.pc));
                        chk("out_data", 64'(bus_if.inst_data), 64'(e.data));
                    end
                end else begin
                    held = 1'b1;
                    held_pc = bus_if.inst_pc;
                    held_data = bus_if.inst_data;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Shared prelude for the redirect tests: deliver 0..2, then stall so
    // words 3/4 sit in the buffer with pc=5
    task automatic stall_at_pc5();
        do_reset();
        load_prog(25);
        push_range(0, 4);
        bus_if.inst_ready = 1'b1;
        pulse_start();
        wait_pop_pc(5'd2, 50);
        @(posedge clk); #1;
        bus_if.inst_ready = 1'b0;
        @(posedge clk); #1;
        chk("stall_imem_addr", 64'(bus_if.imem_addr), 64'd5);
        chk("stall_head_pc", 64'(bus_if.inst_pc), 64'd3);
    endtask

    initial begin
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int c;

        // Reset state
        do_reset();
        chk("rst_valid", 64'(bus_if.inst_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_imem_addr", 64'(bus_if.imem_addr), 64'd0);
        chk("rst_inst_data", 64'(bus_if.inst_data), 64'd0);
        chk("rst_inst_pc", 64'(bus_if.inst_pc), 64'd0);

        // Straight run to a zero word at 25
        load_prog(25);
        push_range(0, 24);
        bus_if.inst_ready = 1'b1;
        pulse_start();
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_imem_addr", 64'(bus_if.imem_addr), 64'd0);
        chk("lat1_valid", 64'(bus_if.inst_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat2_valid", 64'(bus_if.inst_valid), 64'd0);
        @(posedge clk); #1;
        chk("first_valid", 64'(bus_if.inst_valid), 64'd1);
        chk("first_pc", 64'(bus_if.inst_pc), 64'd0);
        wait_halt("t1_halted", 200);
        chk("t1_all_delivered", 64'(exp_q.size()), 64'd0);
        chk("t1_imem_addr", 64'(bus_if.imem_addr), 64'd26);
        chk("t1_busy", 64'(busy), 64'd1);
`ifdef IFETCH_PERF_CNT_EN
        chk("t1_fetch_count", 64'(fetch_count), 64'd25);
        chk("t1_stall_count", 64'(stall_count), 64'd0);
`endif
        // Redirect ignored in HALT
        redirect_valid = 1'b1;
        redirect_addr = 5'd5;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        chk("halt_redirect_addr", 64'(bus_if.imem_addr), 64'd26);
        chk("halt_redirect_halted", 64'(halted), 64'd1);
        // Restart from HALT with a simultaneous redirect: start wins
        push_range(0, 24);
        start = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 5'd7;
        @(posedge clk); #1;
        start = 1'b0;
        redirect_valid = 1'b0;
        chk("restart_imem_addr", 64'(bus_if.imem_addr), 64'd0);
        chk("restart_halted", 64'(halted), 64'd0);
        wait_halt("restart_halted_end", 200);
        chk("restart_all_delivered", 64'(exp_q.size()), 64'd0);
`ifdef IFETCH_PERF_CNT_EN
        chk("restart_fetch_count", 64'(fetch_count), 64'd25);
`endif

        // Back-pressure pattern 1,0,0,1
        do_reset();
        load_prog(25);
        push_range(0, 24);
        pulse_start();
        c = 0;
        while (!halted && c < 400) begin
            bus_if.inst_ready = pat[c % 4];
            @(posedge clk); #1;
            c++;
        end
        chk("t2_halted", 64'(halted), 64'd1);
        chk("t2_all_delivered", 64'(exp_q.size()), 64'd0);
        chk("t2_fifo_over_2", 64'(max_cnt > 2), 64'd0);
        chk("t2_imem_addr", 64'(bus_if.imem_addr), 64'd26);

        // Redirect to 20 with 3/4 buffered, no pop
        stall_at_pc5();
        redirect_valid = 1'b1;
        redirect_addr = 5'd20;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        bus_if.inst_ready = 1'b1;
        exp_q.delete();
        push_range(20, 24);
        chk("t3_r1_valid", 64'(bus_if.inst_valid), 64'd0);
        chk("t3_r1_imem_addr", 64'(bus_if.imem_addr), 64'd20);
        @(posedge clk); #1;
        chk("t3_r2_valid", 64'(bus_if.inst_valid), 64'd0);
        @(posedge clk); #1;
        chk("t3_r3_valid", 64'(bus_if.inst_valid), 64'd1);
        chk("t3_r3_pc", 64'(bus_if.inst_pc), 64'd20);
        wait_halt("t3_halted", 100);
        chk("t3_all_delivered", 64'(exp_q.size()), 64'd0);

        // Redirect to 10 with a pop in the same cycle
        stall_at_pc5();
        bus_if.inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 5'd10;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        exp_q.delete();
        push_range(10, 24);
        chk("t4_pops", 64'(pops), 64'd4);
        chk("t4_r1_valid", 64'(bus_if.inst_valid), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t4_r3_pc", 64'(bus_if.inst_pc), 64'd10);
        wait_halt("t4_halted", 100);
        chk("t4_all_delivered", 64'(exp_q.size()), 64'd0);

        // All words nonzero: stop after LAST_ADDR, no wrap
        do_reset();
        load_prog(32);
        push_range(0, 31);
        bus_if.inst_ready = 1'b1;
        pulse_start();
        wait_halt("t5_halted", 200);
        chk("t5_all_delivered", 64'(exp_q.size()), 64'd0);
        chk("t5_imem_addr", 64'(bus_if.imem_addr), 64'd31);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_wrap_valid", 64'(bus_if.inst_valid), 64'd0);
        chk("t5_still_halted", 64'(halted), 64'd1);
`ifdef IFETCH_PERF_CNT_EN
        chk("t5_fetch_count", 64'(fetch_count), 64'd32);
`endif

        // Reset mid-RUN with the buffer full
        do_reset();
        load_prog(25);
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        chk("t6_full_valid", 64'(bus_if.inst_valid), 64'd1);
        chk("t6_full_pc", 64'(bus_if.inst_pc), 64'd0);
        chk("t6_full_imem_addr", 64'(bus_if.imem_addr), 64'd2);
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_valid", 64'(bus_if.inst_valid), 64'd0);
        chk("t6_imem_addr", 64'(bus_if.imem_addr), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_inst_data", 64'(bus_if.inst_data), 64'd0);
`ifdef IFETCH_PERF_CNT_EN
        chk("t6_fetch_count", 64'(fetch_count), 64'd0);
        chk("t6_stall_count", 64'(stall_count), 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
